// File: rtl/dz_countdown_ctrl_if.sv
// Signal bundle between the countdown controller, its pulse sources, the digit
// font and the 8x8 red/green matrix.
`timescale 1ns / 1ps

interface dz_countdown_ctrl_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] glyph_bits;
  logic [3:0] glyph_idx;
  logic [2:0] glyph_row;
  logic [3:0] cnt;
  logic       done;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;

  // Control/font side: issues pulses, answers font lookups, watches the matrix.
  modport master (
    output start, pause, clear, glyph_bits,
    input  glyph_idx, glyph_row, cnt, done, row, colr, colg
  );

  // Controller side.
  modport slave (
    input  start, pause, clear, glyph_bits,
    output glyph_idx, glyph_row, cnt, done, row, colr, colg
  );
endinterface

// File: rtl/dz_countdown_ctrl.sv
// Countdown sequencer for the 8x8 red/green dot-matrix display: run/pause/done
// state machine, tick prescaler, count value, row scan and coloured column drive.
`timescale 1ns / 1ps

module dz_countdown_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned SCAN_DIV  = 1,
  parameter int unsigned START_VAL = 5
) (
  input logic                clk,
  input logic                rst,
  dz_countdown_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PLast   = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLast   = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    CntInit = 4'(START_VAL);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e        state_q;
  logic [PW-1:0] p_q;
  logic [3:0]    cnt_q;
  logic          blink_q;
  logic          done_q;
  logic [SW-1:0] s_q;
  logic [2:0]    r_q;
  logic [7:0]    row_q;
  logic [7:0]    colr_q;
  logic [7:0]    colg_q;

  logic          tick;
  logic [PW-1:0] p_next;

  assign tick   = (p_q == PLast);
  assign p_next = tick ? '0 : p_q + PW'(1);

  // Run/pause/done sequencing with prescaler, count, blink and done flag.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_q <= StIdle;
      cnt_q   <= CntInit;
      p_q     <= '0;
      blink_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
            cnt_q   <= CntInit;
            p_q     <= '0;
          end
        end
        StRun: begin
          if (bus.pause) begin
            // Prescaler freezes, even on a coincident tick.
            state_q <= StPause;
          end else if (cnt_q == 4'd0) begin
            // Zero reload value: finish without waiting for a tick.
            state_q <= StDone;
            done_q  <= 1'b1;
            blink_q <= 1'b1;
            p_q     <= '0;
          end else begin
            p_q <= p_next;
            if (tick) begin
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                state_q <= StDone;
                done_q  <= 1'b1;
                blink_q <= 1'b1;
              end
            end
          end
        end
        StPause: begin
          if (bus.pause) begin
            state_q <= StRun;
          end
        end
        StDone: begin
          if (bus.start) begin
            state_q <= StRun;
            cnt_q   <= CntInit;
            p_q     <= '0;
            done_q  <= 1'b0;
          end else begin
            p_q <= p_next;
            if (tick) begin
              blink_q <= ~blink_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Free-running row scan and registered row/column drive coloured by state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      r_q    <= 3'd0;
      row_q  <= 8'hFF;
      colr_q <= 8'h00;
      colg_q <= 8'h00;
    end else begin
      if (s_q == SLast) begin
        s_q <= '0;
        r_q <= r_q + 3'd1;
      end else begin
        s_q <= s_q + SW'(1);
      end
      row_q <= ~(8'b1 << r_q);
      case (state_q)
        StIdle: begin
          colr_q <= bus.glyph_bits;
          colg_q <= bus.glyph_bits;
        end
        StRun: begin
          colr_q <= 8'h00;
          colg_q <= bus.glyph_bits;
        end
        StPause: begin
          colr_q <= bus.glyph_bits;
          colg_q <= 8'h00;
        end
        default: begin
          colr_q <= blink_q ? bus.glyph_bits : 8'h00;
          colg_q <= 8'h00;
        end
      endcase
    end
  end

  assign bus.glyph_idx = cnt_q;
  assign bus.glyph_row = r_q;
  assign bus.cnt       = cnt_q;
  assign bus.done      = done_q;
  assign bus.row       = row_q;
  assign bus.colr      = colr_q;
  assign bus.colg      = colg_q;

endmodule

// File: tb/tb_dz_countdown_ctrl.sv
// Bench for dz_countdown_ctrl: a vector table drives the main controller
// (TICK_DIV=4, SCAN_DIV=1, START_VAL=3) through a scoreboard queue, a second
// instance (TICK_DIV=4, SCAN_DIV=2, START_VAL=0) gets a hand-written sequence,
// and the row scan of both is compared every cycle against a cycle-count formula.
`timescale 1ns / 1ps

module tb_dz_countdown_ctrl;

  typedef enum logic [1:0] {CYel, CGrn, CRed, COff} col_e;

  typedef struct {
    logic       rst;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] bits;
    int         wait_n;
    logic [3:0] cnt;
    logic       done;
    col_e       col;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_a = 0;
  int   cyc_b = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  dz_countdown_ctrl_if bus_a ();
  dz_countdown_ctrl_if bus_b ();

  dz_countdown_ctrl #(.TICK_DIV(4), .SCAN_DIV(1), .START_VAL(3)) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a.slave)
  );

  dz_countdown_ctrl #(.TICK_DIV(4), .SCAN_DIV(2), .START_VAL(0)) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b.slave)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Row expected c edges after the last reset edge.
  function automatic logic [7:0] exp_row(input int c, input int div);
    logic [7:0] t;
    if (c == 0) return 8'hFF;
    t = 8'b1 << (((c - 1) / div) % 8);
    return ~t;
  endfunction

  function automatic logic [7:0] exp_grow(input int c, input int div);
    return 8'((c / div) % 8);
  endfunction

  function automatic logic [15:0] exp_cols(input col_e col, input logic [7:0] b);
    case (col)
      CYel:    return {b, b};
      CGrn:    return {8'h00, b};
      CRed:    return {b, 8'h00};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic p, input logic c,
                              input logic [7:0] b, input int w, input logic [3:0] n,
                              input logic d, input col_e col);
    vec_t v;
    v.rst = r; v.start = s; v.pause = p; v.clear = c; v.bits = b;
    v.wait_n = w; v.cnt = n; v.done = d; v.col = col;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc_a <= rst_a ? 0 : cyc_a + 1;
    cyc_b <= rst_b ? 0 : cyc_b + 1;
  end

  // Scan check on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("row_a c%0d", cyc_a), bus_a.row, exp_row(cyc_a, 1));
      check($sformatf("glyph_row_a c%0d", cyc_a), {5'b0, bus_a.glyph_row}, exp_grow(cyc_a, 1));
      check($sformatf("row_b c%0d", cyc_b), bus_b.row, exp_row(cyc_b, 2));
      check($sformatf("glyph_row_b c%0d", cyc_b), {5'b0, bus_b.glyph_row}, exp_grow(cyc_b, 2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[29];
  vec_t exp_q[$];

  initial begin
    vec_t v;
    vec_t e;
    logic [15:0] cols;

    bus_a.start = 1'b0; bus_a.pause = 1'b0; bus_a.clear = 1'b0; bus_a.glyph_bits = 8'hA5;
    bus_b.start = 1'b0; bus_b.pause = 1'b0; bus_b.clear = 1'b0; bus_b.glyph_bits = 8'h5A;

    //              rst  start pause clear bits  wait cnt  done col
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 4'd3, 1'b0, COff);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 3, 4'd3, 1'b0, CYel);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 4'd3, 1'b0, CYel);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 2, 4'd3, 1'b0, CGrn);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 4'd2, 1'b0, CGrn);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 3, 4'd1, 1'b0, CGrn);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 3, 4'd0, 1'b1, CGrn);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 4'd0, 1'b1, CRed);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 3, 4'd0, 1'b1, COff);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 3, 4'd0, 1'b1, CRed);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, 0, 4'd3, 1'b0, CRed);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 3, 4'd2, 1'b0, CGrn);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 0, 4'd2, 1'b0, CGrn);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 9, 4'd2, 1'b0, CRed);
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 0, 4'd2, 1'b0, CRed);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 2, 4'd2, 1'b0, CGrn);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 0, 4'd1, 1'b0, CGrn);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 2, 4'd1, 1'b0, CGrn);
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h0F, 0, 4'd1, 1'b0, CGrn);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F, 1, 4'd1, 1'b0, CRed);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 0, 4'd3, 1'b0, CRed);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 0, 4'd3, 1'b0, CYel);
    vecs[22] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h81, 3, 4'd3, 1'b0, CGrn);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 0, 4'd2, 1'b0, CGrn);
    vecs[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h81, 2, 4'd2, 1'b0, CGrn);
    vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 0, 4'd1, 1'b0, CGrn);
    vecs[26] = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 0, 4'd3, 1'b0, COff);
    vecs[27] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 0, 4'd3, 1'b0, CYel);
    vecs[28] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h66, 2, 4'd3, 1'b0, CYel);

    for (int i = 0; i < 29; i++) begin
      v = vecs[i];
      rst_a = v.rst;
      bus_a.start = v.start;
      bus_a.pause = v.pause;
      bus_a.clear = v.clear;
      bus_a.glyph_bits = v.bits;
      exp_q.push_back(v);
      step();
      chk_en = 1'b1;
      rst_a = 1'b0;
      bus_a.start = 1'b0;
      bus_a.pause = 1'b0;
      bus_a.clear = 1'b0;
      repeat (v.wait_n) step();
      e = exp_q.pop_front();
      cols = exp_cols(e.col, e.bits);
      check($sformatf("v%0d cnt", i), {4'b0, bus_a.cnt}, {4'b0, e.cnt});
      check($sformatf("v%0d glyph_idx", i), {4'b0, bus_a.glyph_idx}, {4'b0, e.cnt});
      check($sformatf("v%0d done", i), {7'b0, bus_a.done}, {7'b0, e.done});
      check($sformatf("v%0d colr", i), bus_a.colr, cols[15:8]);
      check($sformatf("v%0d colg", i), bus_a.colg, cols[7:0]);
    end

    // Zero reload value: start finishes on the following cycle without a tick.
    rst_b = 1'b0;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    check("b0 run cnt", {4'b0, bus_b.cnt}, 8'h00);
    check("b0 run done", {7'b0, bus_b.done}, 8'h00);
    step();
    check("b0 done", {7'b0, bus_b.done}, 8'h01);
    check("b0 done cnt", {4'b0, bus_b.cnt}, 8'h00);
    check("b0 run colg", bus_b.colg, 8'h5A);
    check("b0 run colr", bus_b.colr, 8'h00);
    step();
    check("b0 blink on colr", bus_b.colr, 8'h5A);
    check("b0 blink on colg", bus_b.colg, 8'h00);
    // Pause is ignored in DONE: blinking continues on schedule.
    bus_b.pause = 1'b1;
    step();
    bus_b.pause = 1'b0;
    step();
    check("b0 pause ign done", {7'b0, bus_b.done}, 8'h01);
    check("b0 pause ign colr", bus_b.colr, 8'h5A);
    step();
    step();
    check("b0 blink off colr", bus_b.colr, 8'h00);
    check("b0 blink off done", {7'b0, bus_b.done}, 8'h01);
    // Restart from DONE reloads zero and finishes again.
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    check("b0 restart done", {7'b0, bus_b.done}, 8'h00);
    check("b0 restart cnt", {4'b0, bus_b.cnt}, 8'h00);
    step();
    check("b0 redone", {7'b0, bus_b.done}, 8'h01);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
